adc_sample_source: RTL
======================

Name: adc_sample_source

Overview:
- Front end that drives the `input_sig`/`ready` sample interface consumed by the FIR filters, including the `socket` pair.
- Generates a periodic sample tick, runs the conversion and serial readout of an external 18-bit SPI-style ADC, and presents each sample as an 18-bit signed word with a one-cycle `ready` strobe.
- Sits between the ADC pins and the filter chain.

Parameters:
- SAMPLE_DIV, 1000: clk cycles per sample period; must be ≥ 2.
- CONV_CYCLES, 20: clk cycles `adc_cnv` is held high per conversion; must be ≥ 1.
- SCLK_HALF, 2: clk cycles per `adc_sclk` half-period; must be ≥ 1.
- OFFSET_BINARY, 0: 1 means the ADC word is offset binary and the MSB is inverted to get two's complement; 0 means the ADC word is already two's complement.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enables sample ticks.
- adc_sdo  in  1  ADC serial data, MSB first; assumed stable at the clk edge where `adc_sclk` rises.
- adc_cnv  out  1  conversion start, high for CONV_CYCLES cycles.
- adc_sclk  out  1  serial clock, idles low, registered.
- sample_sig  out  18  signed sample; held between strobes.
- ready  out  1  one-cycle strobe; `sample_sig` is valid in the same cycle.
- overrun  out  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset (async, immediate) drives all outputs to 0: `adc_cnv`, `adc_sclk`, `sample_sig`, `ready`, `overrun`. The state machine goes to IDLE; the sample counter and shift register clear.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1 and wraps while `en`=1.
  - `tick` is asserted in the cycle the counter equals 0 and `en`=1.
  - With `en`=0 the counter is held at 0 and no tick is generated.
- States: IDLE, CONV, SHIFT, DONE.
  - IDLE: on `tick`, go to CONV and set `adc_cnv`=1 from the next cycle.
  - CONV: `adc_cnv` stays high for exactly CONV_CYCLES cycles, then drops; go to SHIFT.
  - SHIFT: 18 `adc_sclk` periods, each SCLK_HALF cycles low then SCLK_HALF cycles high (36·SCLK_HALF cycles total).
    - `adc_sdo` is shifted in, MSB first, at the clk edge where `adc_sclk` goes 0→1.
    - `adc_sclk` is low on exit.
  - DONE (1 cycle): `sample_sig` is loaded from the shift register (MSB inverted if OFFSET_BINARY=1) and `ready`=1; go to IDLE.
- Latency: with the tick in cycle T, `ready` is high in cycle T+CONV_CYCLES+36·SCLK_HALF+1. With defaults this is T+93.
- Minimum overrun-free period is SAMPLE_DIV ≥ CONV_CYCLES+36·SCLK_HALF+2 (94 with defaults).
- Tick while not IDLE: the tick is dropped, the in-flight conversion continues unaffected, and `overrun` is set to 1. `overrun` is cleared only by `rst`.
- `en` falling mid-conversion: the conversion completes and `ready` still pulses; no new ticks are generated.
- `en` rising: the first tick occurs in the first cycle with `en`=1, because the counter is at 0.
- `ready` is never high in two consecutive cycles. `sample_sig` changes only in a `ready` cycle.
- `rst` mid-SHIFT: the partial word is discarded, no `ready` is issued, and the pins return to idle immediately.

Test Plan:
1. Defaults, `en`=1, ADC model returns 18'h1FFFF → `ready` at T+93, `sample_sig` = +131071; `adc_cnv` high for 20 cycles; 18 `adc_sclk` rising edges.
2. ADC returns 18'h20000 → `sample_sig` = −131072. Repeat with OFFSET_BINARY=1 → 0. Repeat OFFSET_BINARY=1 with 18'h00000 → −131072.
3. SAMPLE_DIV=1000, 5 samples with values 1, −1, 2, −2, 0 → `ready` pulses exactly 1000 cycles apart, values in order, `overrun`=0.
4. SAMPLE_DIV=50 → second tick lands during SHIFT; `overrun`=1 and stays 1; every conversion still completes with correct data; `ready` spacing is 100 cycles.
5. `rst` asserted at SHIFT bit 9 → outputs 0 asynchronously, no `ready`. After release with `en`=1, the next sample is correct with latency 93.
6. `en` deasserted 10 cycles after tick → that sample's `ready` still occurs at T+93; no further `adc_cnv` pulses while `en`=0.

Source files
------------

// File: rtl/adc_sample_source_if.sv
// Sample interface between the ADC front end and the FIR filter chain:
// a signed 18-bit word with a one-cycle ready strobe and a sticky overrun flag.
interface adc_sample_source_if;
  logic signed [17:0] sample_sig;
  logic               ready;
  logic               overrun;

  modport master (output sample_sig, output ready, output overrun);
  modport slave  (input  sample_sig, input  ready, input  overrun);
endinterface

// File: rtl/adc_sample_source.sv
// Periodic sample tick, conversion strobe and serial readout of an external
// 18-bit SPI-style ADC, presented as a signed word with a one-cycle ready strobe.
module adc_sample_source #(
  parameter int SAMPLE_DIV    = 1000,
  parameter int CONV_CYCLES   = 20,
  parameter int SCLK_HALF     = 2,
  parameter int OFFSET_BINARY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   adc_sdo,
  output logic                   adc_cnv,
  output logic                   adc_sclk,
  adc_sample_source_if.master    sample
);

  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int PW = $clog2(2 * SCLK_HALF);

  localparam logic [SW-1:0] DIV_LAST  = SW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [PW-1:0] PH_RISE   = PW'(SCLK_HALF - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * SCLK_HALF - 1);
  localparam logic          MSB_FLIP  = (OFFSET_BINARY != 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] scnt;
  logic [CW-1:0] ccnt;
  logic [PW-1:0] ph;
  logic [4:0]    bitcnt;
  logic [17:0]   sreg;
  logic          tick;

  assign tick = en && (scnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
    end else if (!en || scnt == DIV_LAST) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      ccnt              <= '0;
      ph                <= '0;
      bitcnt            <= '0;
      sreg              <= '0;
      adc_cnv           <= 1'b0;
      adc_sclk          <= 1'b0;
      sample.sample_sig <= '0;
      sample.ready      <= 1'b0;
      sample.overrun    <= 1'b0;
    end else begin
      sample.ready <= 1'b0;
      if (tick && state != IDLE) begin
        sample.overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state   <= CONV;
            adc_cnv <= 1'b1;
            ccnt    <= '0;
          end
        end
        CONV: begin
          if (ccnt == CONV_LAST) begin
            state   <= SHIFT;
            adc_cnv <= 1'b0;
            ph      <= '0;
            bitcnt  <= '0;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        SHIFT: begin
          // sclk is registered, so the data bit is captured on the same edge
          // that drives sclk high.
          if (ph == PH_RISE) begin
            adc_sclk <= 1'b1;
            sreg     <= {sreg[16:0], adc_sdo};
          end
          if (ph == PH_LAST) begin
            adc_sclk <= 1'b0;
            ph       <= '0;
            if (bitcnt == 5'd17) begin
              state             <= DONE;
              sample.sample_sig <= {sreg[17] ^ MSB_FLIP, sreg[16:0]};
              sample.ready      <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
